// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan generator for the pixel renderers.
// Produces the pixel counters (DrawX/DrawY) and the display enable (blank).
// blank=1 means the pixel is visible. blank, line_start and frame_start are
// decoded from the counters with zero latency. hs, vs and blank_d are delayed
// by PIPE_DELAY clocks so they line up with the registered RGB.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       blank_d,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_param_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and PIPE_DELAY in 0..7");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Pipeline contents are {hs, vs, blank}; reset leaves syncs idle and the DAC blanked.
  localparam logic [2:0] PIPE_RST = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] raw;
  logic [2:0] dly;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  // Horizontal counter runs every clock; vertical advances on each horizontal wrap.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (h_wrap) begin
      hc <= '0;
      vc <= v_wrap ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = (hc < H_VIS) && (vc < V_VIS);
  assign line_start  = (hc == '0);
  assign frame_start = (hc == '0) && (vc == '0);

  assign hs_raw = ((hc >= HS_FIRST) && (hc <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vs_raw = ((vc >= VS_FIRST) && (vc <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign raw    = {hs_raw, vs_raw, blank};

  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] stage [PIPE_DELAY];

    // Shift register matching the renderer ROM + output flop latency.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= PIPE_RST;
      end else begin
        stage[0] <= raw;
        for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign dly = stage[PIPE_DELAY-1];
  end

  assign {hs, vs, blank_d} = dly;

`ifdef VGA_FRAME_COUNT_EN
  // Counts completed frames; steps on the edge where both counters wrap to 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)               frame_count <= '0;
    else if (h_wrap && v_wrap)  frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed expectations keyed by (reset phase, clocks since
// release) are queued up front; a negedge monitor pops and compares them.
module tb_vga_timing_gen;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d2_x, d2_y, d0_x, d0_y, sm_x, sm_y;
  logic d2_bl, d2_bld, d2_hs, d2_vs, d2_ls, d2_fs;
  logic d0_bl, d0_bld, d0_hs, d0_vs, d0_ls, d0_fs;
  logic sm_bl, sm_bld, sm_hs, sm_vs, sm_ls, sm_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] d2_fc, d0_fc, sm_fc;
`endif

  vga_timing_gen #(.PIPE_DELAY(2)) u_d2 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d2_x), .DrawY(d2_y),
    .blank(d2_bl), .blank_d(d2_bld), .hs(d2_hs), .vs(d2_vs),
    .line_start(d2_ls), .frame_start(d2_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(d2_fc)
`endif
  );

  vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(d0_x), .DrawY(d0_y),
    .blank(d0_bl), .blank_d(d0_bld), .hs(d0_hs), .vs(d0_vs),
    .line_start(d0_ls), .frame_start(d0_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(d0_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b1), .PIPE_DELAY(0)
  ) u_sm (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(sm_x), .DrawY(sm_y),
    .blank(sm_bl), .blank_d(sm_bld), .hs(sm_hs), .vs(sm_vs),
    .line_start(sm_ls), .frame_start(sm_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(sm_fc)
`endif
  );

  typedef enum int {
    D2X, D2Y, D2BL, D2BLD, D2HS, D2VS,
    D0X, D0Y, D0BLD, D0HS, D0VS, D0LS, D0FS,
    SMX, SMY, SMBL, SMBLD, SMHS, SMVS, SMFS, SMFC,
    A_D0HSLO, A_D0BL, A_SMVSHI, A_SMLS, A_SMFS
  } sel_e;

  typedef struct {
    int    phase;
    int    k;
    sel_e  sel;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int phase  = 0;
  int k      = 0;
  int acc_d0_hslo, acc_d0_bl, acc_sm_vshi, acc_sm_ls, acc_sm_fs;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void push(input int ph, input int kk, input sel_e s, input int e, input string n);
    exp_t x;
    int i;
    x.phase = ph; x.k = kk; x.sel = s; x.exp = e; x.name = n;
    i = 0;
    while (i < sb.size() && (sb[i].phase < ph || (sb[i].phase == ph && sb[i].k <= kk))) i++;
    sb.insert(i, x);
  endfunction

  function automatic int getsig(input sel_e s);
    case (s)
      D2X:      return int'(d2_x);
      D2Y:      return int'(d2_y);
      D2BL:     return int'(d2_bl);
      D2BLD:    return int'(d2_bld);
      D2HS:     return int'(d2_hs);
      D2VS:     return int'(d2_vs);
      D0X:      return int'(d0_x);
      D0Y:      return int'(d0_y);
      D0BLD:    return int'(d0_bld);
      D0HS:     return int'(d0_hs);
      D0VS:     return int'(d0_vs);
      D0LS:     return int'(d0_ls);
      D0FS:     return int'(d0_fs);
      SMX:      return int'(sm_x);
      SMY:      return int'(sm_y);
      SMBL:     return int'(sm_bl);
      SMBLD:    return int'(sm_bld);
      SMHS:     return int'(sm_hs);
      SMVS:     return int'(sm_vs);
      SMFS:     return int'(sm_fs);
`ifdef VGA_FRAME_COUNT_EN
      SMFC:     return int'(sm_fc);
`endif
      A_D0HSLO: return acc_d0_hslo;
      A_D0BL:   return acc_d0_bl;
      A_SMVSHI: return acc_sm_vshi;
      A_SMLS:   return acc_sm_ls;
      A_SMFS:   return acc_sm_fs;
      default:  return -1;
    endcase
  endfunction

  // Track reset phases and clocks since release.
  always @(posedge reset_n) begin
    phase++;
    k = 0;
    acc_d0_hslo = 0; acc_d0_bl = 0; acc_sm_vshi = 0; acc_sm_ls = 0; acc_sm_fs = 0;
  end

  always @(posedge clk) if (reset_n) k++;

  // Monitor: accumulate window statistics, then retire due scoreboard entries.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (k >= 1 && k <= 800) begin
        acc_d0_hslo += int'(d0_hs == 1'b0);
        acc_d0_bl   += int'(d0_bl);
      end
      if (k >= 1 && k <= 48) begin
        acc_sm_vshi += int'(sm_vs);
        acc_sm_ls   += int'(sm_ls);
      end
      if (k >= 1 && k <= 144) acc_sm_fs += int'(sm_fs);
      while (sb.size() > 0 && (sb[0].phase < phase || (sb[0].phase == phase && sb[0].k <= k))) begin
        e = sb.pop_front();
        if (e.phase == phase && e.k == k) check(e.name, getsig(e.sel), e.exp);
        else begin
          checks++;
          errors++;
          $display("FAIL %s missed sample actual=none required=%0d", e.name, e.exp);
        end
      end
    end
  end

  initial begin
    // Phase 1: defaults with PIPE_DELAY 2 and 0, plus the small raster.
    push(1,   1, D2X,   1,   "d2_x_first_edge");
    push(1,   1, D2HS,  1,   "d2_hs_reset_stage");
    push(1,   1, D2VS,  1,   "d2_vs_reset_stage");
    push(1,   1, D2BLD, 0,   "d2_bld_reset_stage");
    push(1,   2, D2BLD, 1,   "d2_bld_first_visible");
    push(1, 639, D2BL,  1,   "d2_bl_639");
    push(1, 640, D2BL,  0,   "d2_bl_640");
    push(1, 641, D2BLD, 1,   "d2_bld_641");
    push(1, 642, D2BLD, 0,   "d2_bld_642");
    push(1, 657, D2HS,  1,   "d2_hs_657");
    push(1, 658, D2HS,  0,   "d2_hs_658");
    push(1, 753, D2HS,  0,   "d2_hs_753");
    push(1, 754, D2HS,  1,   "d2_hs_754");
    push(1, 799, D2X,   799, "d2_x_799");
    push(1, 799, D2Y,   0,   "d2_y_799");
    push(1, 800, D2X,   0,   "d2_x_wrap");
    push(1, 800, D2Y,   1,   "d2_y_wrap");

    push(1,   1, D0BLD, 1,   "d0_bld_nodelay");
    push(1, 640, D0BLD, 0,   "d0_bld_640");
    push(1, 655, D0HS,  1,   "d0_hs_655");
    push(1, 656, D0HS,  0,   "d0_hs_656");
    push(1, 751, D0HS,  0,   "d0_hs_751");
    push(1, 752, D0HS,  1,   "d0_hs_752");
    push(1, 799, D0LS,  0,   "d0_ls_799");
    push(1, 800, D0LS,  1,   "d0_ls_800");
    push(1, 800, D0FS,  0,   "d0_fs_line1");
    push(1, 800, A_D0HSLO, 96,  "d0_hs_low_clocks");
    push(1, 800, A_D0BL,   640, "d0_blank_clocks");

    push(1,   3, SMBL, 1, "sm_bl_3");
    push(1,   4, SMBL, 0, "sm_bl_4");
    push(1,   4, SMHS, 0, "sm_hs_4");
    push(1,   5, SMHS, 1, "sm_hs_5");
    push(1,   6, SMHS, 1, "sm_hs_6");
    push(1,   7, SMHS, 0, "sm_hs_7");
    push(1,  31, SMVS, 0, "sm_vs_31");
    push(1,  32, SMVS, 1, "sm_vs_32");
    push(1,  39, SMVS, 1, "sm_vs_39");
    push(1,  40, SMVS, 0, "sm_vs_40");
    push(1,  47, SMX,  7, "sm_x_last");
    push(1,  47, SMY,  5, "sm_y_last");
    push(1,  47, SMFS, 0, "sm_fs_47");
    push(1,  48, SMX,  0, "sm_x_frame_wrap");
    push(1,  48, SMY,  0, "sm_y_frame_wrap");
    push(1,  48, SMFS, 1, "sm_fs_48");
    push(1,  48, A_SMVSHI, 8, "sm_vs_high_clocks");
    push(1,  48, A_SMLS,   6, "sm_line_starts");
    push(1, 144, A_SMFS,   3, "sm_frame_starts");
`ifdef VGA_FRAME_COUNT_EN
    push(1,  47, SMFC, 0, "sm_fc_47");
    push(1,  48, SMFC, 1, "sm_fc_48");
    push(1,  96, SMFC, 2, "sm_fc_96");
    push(1, 144, SMFC, 3, "sm_fc_144");
    push(2,  47, SMFC, 65535, "sm_fc_preload");
    push(2,  48, SMFC, 0,     "sm_fc_wrap");
`endif

    // Phase 2: after a mid-line reset.
    push(2,  1, D2X,   1, "d2_x_after_rst");
    push(2,  1, D2Y,   0, "d2_y_after_rst");
    push(2,  1, D2HS,  1, "d2_hs_hold_after_rst");
    push(2,  1, D2BLD, 0, "d2_bld_hold_after_rst");
    push(2,  2, D2BLD, 1, "d2_bld_after_rst");
    push(2, 47, SMFS,  0, "sm_fs_47_after_rst");
    push(2, 48, SMFS,  1, "sm_fs_48_after_rst");
    push(2, 96, SMFS,  1, "sm_fs_96_after_rst");

    #1 reset_n = 1'b0;
    #2;
    check("rst_d2_x",   int'(d2_x),   0);
    check("rst_d2_hs",  int'(d2_hs),  1);
    check("rst_d2_bld", int'(d2_bld), 0);
    check("rst_sm_hs",  int'(sm_hs),  0);
    #19 reset_n = 1'b1;

    repeat (1100) @(posedge clk);
    #2;
    check("pre_rst_d2_x", int'(d2_x), 300);
    check("pre_rst_d2_y", int'(d2_y), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_d2_x",  int'(d2_x),   0);
    check("async_rst_d2_y",  int'(d2_y),   0);
    check("async_rst_d2_bl", int'(d2_bl),  1);
    check("async_rst_d2_ls", int'(d2_ls),  1);
    check("async_rst_d2_fs", int'(d2_fs),  1);
    check("async_rst_d2_hs", int'(d2_hs),  1);
    check("async_rst_d2_vs", int'(d2_vs),  1);
    check("async_rst_d2_bld", int'(d2_bld), 0);
    check("async_rst_sm_x",  int'(sm_x),   0);
    @(negedge clk);
    #2 reset_n = 1'b1;

`ifdef VGA_FRAME_COUNT_EN
    repeat (40) @(posedge clk);
    #2 force u_sm.frame_count = 16'hFFFF;
    #1 release u_sm.frame_count;
    repeat (110) @(posedge clk);
`else
    repeat (150) @(posedge clk);
`endif
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
